// File: rtl/code_sequencer.sv
// -----------------------------------------------------------------------------
// code_sequencer
// Phase-code (BPSK chip) sequencer for the HFSWR transmitter baseband.
// A start trigger plays an N-chip binary code, LSB first. Each chip is held
// for chip_samples clock cycles and is mapped to +amplitude (bit=1) or to the
// bitwise inverse of {0,amplitude} (bit=0) on code_out.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-low reset
//   start        single-cycle trigger, honoured only while idle
//   abort        stop the running sequence immediately
//   continuous   restart at chip 0 after the last chip with no gap
//   code_word    chip bits, chip k = code_word[k]
//   code_len     number of chips (1..MAX_CHIPS)
//   chip_samples samples per chip (>= 1)
//   amplitude    unsigned magnitude for the chip mapping
//   code_out     signed sample to the modulator/DAC path
//   busy         sequence in progress
//   done         one-cycle pulse on the first idle cycle after a run ends
//   err          one-cycle pulse when start is rejected for a bad config
//   chip_idx     index of the chip currently on code_out
// -----------------------------------------------------------------------------
module code_sequencer #(
  parameter int NB_OUTPUT = 16,
  parameter int MAX_CHIPS = 64,
  parameter int NB_LEN    = 7,
  parameter int NB_CHIP   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  continuous,
  input  logic [MAX_CHIPS-1:0]  code_word,
  input  logic [NB_LEN-1:0]     code_len,
  input  logic [NB_CHIP-1:0]    chip_samples,
  input  logic [NB_OUTPUT-2:0]  amplitude,
  output logic [NB_OUTPUT-1:0]  code_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [NB_LEN-1:0]     chip_idx
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [NB_LEN-1:0]  MAX_LEN = NB_LEN'(MAX_CHIPS);
  localparam logic [NB_LEN-1:0]  LEN_ONE = {{(NB_LEN-1){1'b0}}, 1'b1};
  localparam logic [NB_CHIP-1:0] CNT_ONE = {{(NB_CHIP-1){1'b0}}, 1'b1};

  // Map one chip bit to its output sample: +mag for 1, ~mag for 0.
  function automatic logic [NB_OUTPUT-1:0] chip_value(
    input logic                 chip_bit,
    input logic [NB_OUTPUT-2:0] amp
  );
    logic [NB_OUTPUT-1:0] mag;
    mag = {1'b0, amp};
    if (chip_bit) begin
      chip_value = mag;
    end else begin
      chip_value = ~mag;
    end
  endfunction

  state_t                state_r, state_nxt_s;
  logic [MAX_CHIPS-1:0]  word_l_r, word_l_nxt_s;
  logic [NB_LEN-1:0]     len_l_r, len_l_nxt_s;
  logic [NB_CHIP-1:0]    cs_l_r, cs_l_nxt_s;
  logic [NB_OUTPUT-2:0]  amp_l_r, amp_l_nxt_s;
  logic [NB_CHIP-1:0]    sample_cnt_r, sample_cnt_nxt_s;
  logic [NB_LEN-1:0]     chip_idx_r, chip_idx_nxt_s;
  logic [NB_OUTPUT-1:0]  code_out_r, code_out_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  done_r, done_nxt_s;
  logic                  err_r, err_nxt_s;

  logic                  cfg_valid_s;
  logic [NB_LEN-1:0]     idx_inc_s;
  logic [MAX_CHIPS-1:0]  word_shift_s;

  // Config check on the live inputs and the bit of the chip that follows.
  always_comb begin
    cfg_valid_s  = (code_len != '0) && (code_len <= MAX_LEN) && (chip_samples != '0);
    idx_inc_s    = chip_idx_r + LEN_ONE;
    // Shift rather than index so the 7-bit chip index fits the 64-bit word.
    word_shift_s = word_l_r >> idx_inc_s;
  end

  // Next-state and next-output logic for the IDLE/RUN sequencer.
  always_comb begin
    state_nxt_s      = state_r;
    word_l_nxt_s     = word_l_r;
    len_l_nxt_s      = len_l_r;
    cs_l_nxt_s       = cs_l_r;
    amp_l_nxt_s      = amp_l_r;
    sample_cnt_nxt_s = sample_cnt_r;
    chip_idx_nxt_s   = chip_idx_r;
    code_out_nxt_s   = code_out_r;
    busy_nxt_s       = busy_r;
    done_nxt_s       = 1'b0;
    err_nxt_s        = 1'b0;

    case (state_r)
      ST_IDLE: begin
        code_out_nxt_s   = '0;
        busy_nxt_s       = 1'b0;
        chip_idx_nxt_s   = '0;
        sample_cnt_nxt_s = '0;
        // abort is deliberately not looked at here: start wins in IDLE.
        if (start) begin
          if (cfg_valid_s) begin
            word_l_nxt_s   = code_word;
            len_l_nxt_s    = code_len;
            cs_l_nxt_s     = chip_samples;
            amp_l_nxt_s    = amplitude;
            state_nxt_s    = ST_RUN;
            busy_nxt_s     = 1'b1;
            code_out_nxt_s = chip_value(code_word[0], amplitude);
          end else begin
            err_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_nxt_s      = ST_IDLE;
          code_out_nxt_s   = '0;
          busy_nxt_s       = 1'b0;
          done_nxt_s       = 1'b1;
          chip_idx_nxt_s   = '0;
          sample_cnt_nxt_s = '0;
        end else if (sample_cnt_r < (cs_l_r - CNT_ONE)) begin
          sample_cnt_nxt_s = sample_cnt_r + CNT_ONE;
        end else begin
          sample_cnt_nxt_s = '0;
          if (chip_idx_r < (len_l_r - LEN_ONE)) begin
            chip_idx_nxt_s = idx_inc_s;
            code_out_nxt_s = chip_value(word_shift_s[0], amp_l_r);
          end else if (continuous) begin
            chip_idx_nxt_s = '0;
            code_out_nxt_s = chip_value(word_l_r[0], amp_l_r);
          end else begin
            state_nxt_s    = ST_IDLE;
            code_out_nxt_s = '0;
            busy_nxt_s     = 1'b0;
            done_nxt_s     = 1'b1;
            chip_idx_nxt_s = '0;
          end
        end
      end

      default: begin
        state_nxt_s      = ST_IDLE;
        code_out_nxt_s   = '0;
        busy_nxt_s       = 1'b0;
        chip_idx_nxt_s   = '0;
        sample_cnt_nxt_s = '0;
      end
    endcase
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      word_l_r     <= '0;
      len_l_r      <= '0;
      cs_l_r       <= '0;
      amp_l_r      <= '0;
      sample_cnt_r <= '0;
      chip_idx_r   <= '0;
      code_out_r   <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      word_l_r     <= word_l_nxt_s;
      len_l_r      <= len_l_nxt_s;
      cs_l_r       <= cs_l_nxt_s;
      amp_l_r      <= amp_l_nxt_s;
      sample_cnt_r <= sample_cnt_nxt_s;
      chip_idx_r   <= chip_idx_nxt_s;
      code_out_r   <= code_out_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      err_r        <= err_nxt_s;
    end
  end

  assign code_out = code_out_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign chip_idx = chip_idx_r;

endmodule

// File: tb/tb_code_sequencer.sv
// -----------------------------------------------------------------------------
// tb_code_sequencer
// Scoreboard bench for code_sequencer. Each test task pushes the expected
// per-cycle output word {code_out, busy, done, err, chip_idx} into a queue as
// it drives stimulus, then pops one entry per clock and compares it with the
// DUT outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_code_sequencer;

  localparam int NB_OUTPUT = 16;
  localparam int MAX_CHIPS = 64;
  localparam int NB_LEN    = 7;
  localparam int NB_CHIP   = 16;
  localparam int NB_OBS    = NB_OUTPUT + 3 + NB_LEN;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic                 continuous;
  logic [MAX_CHIPS-1:0] code_word;
  logic [NB_LEN-1:0]    code_len;
  logic [NB_CHIP-1:0]   chip_samples;
  logic [NB_OUTPUT-2:0] amplitude;
  logic [NB_OUTPUT-1:0] code_out;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [NB_LEN-1:0]    chip_idx;

  logic [NB_OBS-1:0] exp_q[$];
  logic [NB_OBS-1:0] exp_v;
  logic [NB_OBS-1:0] obs_v;
  int checks;
  int fails;

  code_sequencer #(
    .NB_OUTPUT(NB_OUTPUT),
    .MAX_CHIPS(MAX_CHIPS),
    .NB_LEN(NB_LEN),
    .NB_CHIP(NB_CHIP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .continuous(continuous),
    .code_word(code_word),
    .code_len(code_len),
    .chip_samples(chip_samples),
    .amplitude(amplitude),
    .code_out(code_out),
    .busy(busy),
    .done(done),
    .err(err),
    .chip_idx(chip_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NB_OBS-1:0] mk(input logic [NB_OUTPUT-1:0] val, input logic b,
                                           input logic d, input logic e, input logic [NB_LEN-1:0] idx);
    mk = {val, b, d, e, idx};
  endfunction

  function automatic logic [NB_OUTPUT-1:0] model_chip(input logic bit_v, input logic [NB_OUTPUT-2:0] amp);
    logic [NB_OUTPUT-1:0] m;
    m = {1'b0, amp};
    model_chip = bit_v ? m : ~m;
  endfunction

  // Push the busy samples of one full pass through the code.
  task automatic push_busy(input logic [MAX_CHIPS-1:0] w, input int len, input int cs,
                           input logic [NB_OUTPUT-2:0] amp);
    for (int k = 0; k < len; k++)
      for (int s = 0; s < cs; s++)
        exp_q.push_back(mk(model_chip(w[k], amp), 1'b1, 1'b0, 1'b0, NB_LEN'(k)));
  endtask

  task automatic push_done();
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b1, 1'b0, 7'd0));
  endtask

  task automatic push_idle();
    exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b0, 7'd0));
  endtask

  task automatic drive_start(input logic [MAX_CHIPS-1:0] w, input logic [NB_LEN-1:0] len,
                             input logic [NB_CHIP-1:0] cs, input logic [NB_OUTPUT-2:0] amp);
    code_word    = w;
    code_len     = len;
    chip_samples = cs;
    amplitude    = amp;
    start        = 1'b1;
  endtask

  task automatic test_reset();
    int i;
    rst = 1'b0; start = 1'b1; abort = 1'b0; continuous = 1'b0;
    code_word = 64'h1F35; code_len = 7'd13; chip_samples = 16'd2; amplitude = 15'h7FFF;
    for (int k = 0; k < 3; k++) push_idle();
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL reset cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      i++;
    end
    start = 1'b0;
    rst   = 1'b1;
    push_idle();
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    obs_v = {code_out, busy, done, err, chip_idx};
    checks++;
    if (obs_v !== exp_v) begin
      fails++;
      $display("FAIL reset_release: got %h expected %h", obs_v, exp_v);
    end
  endtask

  task automatic test_barker();
    int i;
    drive_start(64'h1F35, 7'd13, 16'd2, 15'h7FFF);
    push_busy(64'h1F35, 13, 2, 15'h7FFF);
    push_done();
    push_idle();
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL barker cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      if (i == 0) start = 1'b0;
      i++;
    end
  endtask

  task automatic test_amplitude();
    int i;
    drive_start(64'h2, 7'd2, 16'd1, 15'h1000);
    exp_q.push_back(mk(16'hEFFF, 1'b1, 1'b0, 1'b0, 7'd0));
    exp_q.push_back(mk(16'h1000, 1'b1, 1'b0, 1'b0, 7'd1));
    push_done();
    push_idle();
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL amplitude cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      if (i == 0) start = 1'b0;
      i++;
    end
  endtask

  task automatic test_continuous();
    int i;
    continuous = 1'b1;
    drive_start(64'h5, 7'd3, 16'd4, 15'h4000);
    for (int p = 0; p < 3; p++) push_busy(64'h5, 3, 4, 15'h4000);
    push_done();
    push_idle();
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL continuous cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      if (i == 0) start = 1'b0;
      // Drop continuous partway through the third period.
      if (i == 26) continuous = 1'b0;
      i++;
    end
  endtask

  task automatic test_abort();
    int i;
    drive_start(64'h1F35, 7'd13, 16'd2, 15'h7FFF);
    push_busy(64'h1F35, 13, 2, 15'h7FFF);
    for (i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL abort_run cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      if (i == 0) start = 1'b0;
    end
    abort = 1'b1;
    exp_q.delete();
    push_done();
    push_idle();
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL abort_end cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      abort = 1'b0;
      i++;
    end
    // start together with abort while idle: the start must still be taken.
    abort = 1'b1;
    drive_start(64'h1, 7'd1, 16'd3, 15'h0005);
    push_busy(64'h1, 1, 3, 15'h0005);
    push_done();
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL start_abort_idle cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      start = 1'b0;
      abort = 1'b0;
      i++;
    end
  endtask

  task automatic test_reset_midrun();
    int i;
    drive_start(64'h1F35, 7'd13, 16'd2, 15'h7FFF);
    push_busy(64'h1F35, 13, 2, 15'h7FFF);
    for (i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL rst_run cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      if (i == 0) start = 1'b0;
    end
    rst = 1'b0;
    exp_q.delete();
    push_idle();
    push_idle();
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL rst_midrun cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      rst = 1'b1;
      i++;
    end
  endtask

  task automatic test_invalid();
    logic [NB_LEN-1:0]  lens[3];
    logic [NB_CHIP-1:0] css[3];
    lens = '{7'd0, 7'd3, 7'd65};
    css  = '{16'd2, 16'd0, 16'd1};
    for (int t = 0; t < 3; t++) begin
      drive_start(64'hFFFF, lens[t], css[t], 15'h1234);
      exp_q.push_back(mk(16'h0000, 1'b0, 1'b0, 1'b1, 7'd0));
      push_idle();
      for (int c = 0; c < 2; c++) begin
        @(posedge clk); #1;
        exp_v = exp_q.pop_front();
        obs_v = {code_out, busy, done, err, chip_idx};
        checks++;
        if (obs_v !== exp_v) begin
          fails++;
          $display("FAIL invalid case %0d cyc %0d: got %h expected %h", t, c, obs_v, exp_v);
        end
        start = 1'b0;
      end
    end
  endtask

  task automatic test_ignored_start();
    int i;
    drive_start(64'h6, 7'd3, 16'd2, 15'h2000);
    push_busy(64'h6, 3, 2, 15'h2000);
    push_done();
    push_idle();
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL ignored_start cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      if (i == 0) start = 1'b0;
      // Restart attempts with a different config mid-run and on the last sample.
      if (i == 1 || i == 5) drive_start(64'hFFFF_FFFF, 7'd5, 16'd1, 15'h7FFF);
      if (i == 2 || i == 6) start = 1'b0;
      i++;
    end
  endtask

  task automatic test_back_to_back();
    int i;
    drive_start(64'h1, 7'd2, 16'd1, 15'h0000);
    push_busy(64'h1, 2, 1, 15'h0000);
    push_done();
    push_busy(64'h1, 1, 3, 15'h0123);
    push_done();
    push_idle();
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      if (i == 0 || i == 3) start = 1'b0;
      if (i == 2) drive_start(64'h1, 7'd1, 16'd3, 15'h0123);
      i++;
    end
  endtask

  task automatic test_edge_len();
    int i;
    drive_start(64'h7FFF_FFFF_FFFF_FFFF, 7'd64, 16'd1, 15'h7FFF);
    push_busy(64'h7FFF_FFFF_FFFF_FFFF, 64, 1, 15'h7FFF);
    push_done();
    push_idle();
    i = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      obs_v = {code_out, busy, done, err, chip_idx};
      checks++;
      if (obs_v !== exp_v) begin
        fails++;
        $display("FAIL edge_len cyc %0d: got %h expected %h", i, obs_v, exp_v);
      end
      if (i == 0) start = 1'b0;
      i++;
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_barker();
    test_amplitude();
    test_continuous();
    test_abort();
    test_reset_midrun();
    test_invalid();
    test_ignored_start();
    test_back_to_back();
    test_edge_len();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/code_sequencer.md
Name: code_sequencer

Overview:
- Parametrised phase-code (BPSK chip) sequencer for the HFSWR transmitter baseband.
- On a start trigger it plays an N-chip binary code, for example Barker or a complementary code. Each chip is held for a programmable number of samples.
- Each chip is mapped to a signed full-scale or programmable amplitude on code_out, which feeds the modulator/DAC path.
- Supports single-shot or continuous repetition, abort, and busy/done/error status.

Parameters:
- NB_OUTPUT, 16, width of the signed two's-complement sample output.
- MAX_CHIPS, 64, maximum code length. Width of code_word.
- NB_LEN, 7, width of code_len and chip_idx. Must satisfy 2^NB_LEN > MAX_CHIPS.
- NB_CHIP, 16, width of the samples-per-chip setting.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle trigger. Honoured only when busy=0.
- abort  in  1  stops the sequence immediately.
- continuous  in  1  1 = restart at chip 0 after the last chip with no gap.
- code_word  in  MAX_CHIPS  chip bits. Chip k = code_word[k], LSB is played first.
- code_len  in  NB_LEN  number of chips. Valid range is 1..MAX_CHIPS.
- chip_samples  in  NB_CHIP  samples per chip. Valid range is >= 1.
- amplitude  in  NB_OUTPUT-1  unsigned magnitude.
- code_out  out  NB_OUTPUT  signed sample.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after the final sample of a non-continuous or aborted run.
- err  out  1  one-cycle pulse when start is rejected for an invalid configuration.
- chip_idx  out  NB_LEN  index of the chip currently on code_out.

Behaviour:
- Reset (rst=0 at a clk edge):
  - code_out=0, busy=0, done=0, err=0, chip_idx=0, internal sample counter=0, state IDLE.
  - Reset overrides every other input, including mid-run.
- Chip mapping:
  - bit=1 gives code_out = {1'b0, amplitude}.
  - bit=0 gives code_out = ~{1'b0, amplitude} (bitwise inverse).
  - With amplitude=0x7FFF this yields 0x7FFF and 0x8000. With amplitude=0 it yields 0x0000 and 0xFFFF.
- States: IDLE and RUN.
- IDLE:
  - code_out=0.
  - On start=1, config is validated. An invalid config is code_len=0, code_len>MAX_CHIPS, or chip_samples=0.
  - Invalid: stay in IDLE, err=1 for one cycle.
  - Valid: latch code_word, code_len, chip_samples and amplitude. Go to RUN.
  - On the next cycle after accepting start: busy=1, chip_idx=0, code_out = chip 0 value. Latency start->first sample is one cycle.
- RUN, evaluated each clk edge:
  - abort=1: go to IDLE. Next cycle code_out=0, busy=0, done=1, chip_idx=0. abort has priority over all RUN activity.
  - Otherwise, if sample_cnt < chip_samples_l-1: increment sample_cnt, outputs hold.
  - Otherwise, at chip end: sample_cnt=0. If chip_idx < code_len_l-1, increment chip_idx and update code_out.
  - Otherwise, at the last chip: if continuous=1 (sampled at this edge), set chip_idx=0, output chip 0, stay busy, done stays 0. If continuous=0, go to IDLE with code_out=0, busy=0, done=1.
- Timing and restart:
  - A single-shot run is busy for exactly code_len*chip_samples cycles.
  - done coincides with the first idle cycle.
  - start is ignored while busy=1, including the last-sample cycle. The earliest restart is accepted on the done cycle, leaving a one-cycle gap of zero output.
- Config changes while busy have no effect until the next accepted start.
- start and abort together in IDLE: abort is ignored and start is processed normally.
- chip_samples=1 is legal: the chip changes every cycle.
- code_len=MAX_CHIPS is legal: the sequence plays code_word[MAX_CHIPS-1] last.
- The sample counter never wraps beyond chip_samples_l-1. Counter width is NB_CHIP.

Test Plan:
- Barker-13, single shot. code_word=0x1F35, code_len=13, chip_samples=2, amplitude=0x7FFF, pulse start.
  - Expect busy for 26 cycles beginning one cycle after start.
  - code_out sequence 7FFF,7FFF,8000,8000,7FFF,... following bits LSB first.
  - done=1 and code_out=0 on cycle 27.
- Amplitude scaling. amplitude=0x1000, code_word=0x2, code_len=2, chip_samples=1.
  - Expect code_out = 0xEFFF then 0x1000, then done.
- Continuous with deassertion. continuous=1, code_len=3, chip_samples=4.
  - Expect chip 0 to follow chip 2 with no gap for 3 periods.
  - Drop continuous during period 3: expect end after chip 2, then done.
- Abort and reset mid-run. Assert abort at the 5th busy cycle.
  - Expect busy=0, code_out=0, done=1 on the next cycle.
  - Repeat with rst=0 instead: all outputs 0 and done=0.
- Invalid and ignored starts.
  - start with code_len=0 gives err pulse, busy stays 0.
  - start with chip_samples=0 gives err.
  - start while busy is ignored and the sequence is unchanged.
  - start on the done cycle is accepted, with a one-cycle gap.
- Edge lengths. code_len=64, chip_samples=1, code_word=all-ones with bit 63 = 0.
  - Expect 63 samples of +amp, then 1 sample of -amp, then done.
